// File: rtl/scoreboard_ctrl.sv
// scoreboard_ctrl: register pending-write scoreboard and issue/stall control for decode.
// Ports: i_clk/i_rstn, decode request (i_id_*), i_ex_stall, i_flush, writeback (i_wb_*),
//        o_issue/o_stall (comb), o_pending/o_empty/o_drain/o_stall_cycles (registered state).
module scoreboard_ctrl #(
    parameter int NREG = 32,
    parameter int CNTW = 16
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_id_valid,
    input  logic [4:0]      i_id_rs1,
    input  logic [4:0]      i_id_rs2,
    input  logic [4:0]      i_id_rd,
    input  logic            i_id_use_rs1,
    input  logic            i_id_use_rs2,
    input  logic            i_id_regwrite,
    input  logic            i_id_serialize,
    input  logic            i_ex_stall,
    input  logic            i_flush,
    input  logic            i_wb_en,
    input  logic [4:0]      i_wb_rd,
    output logic            o_issue,
    output logic            o_stall,
    output logic [NREG-1:0] o_pending,
    output logic            o_empty,
    output logic            o_drain,
    output logic [CNTW-1:0] o_stall_cycles
);

    typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [NREG-1:0] pending_q, pending_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic [NREG-1:0] rs1_oh, rs2_oh, rd_oh, wb_oh;
    logic [NREG-1:0] eff_pending;
    logic            raw, waw, ser_ok;

    // One-hot decodes; bit 0 never matters since pending bit 0 is held at 0.
    always_comb begin
        rs1_oh = '0;
        rs2_oh = '0;
        rd_oh  = '0;
        wb_oh  = '0;
        for (int i = 1; i < NREG; i++) begin
            rs1_oh[i] = (int'(i_id_rs1) == i);
            rs2_oh[i] = (int'(i_id_rs2) == i);
            rd_oh[i]  = (int'(i_id_rd) == i);
            wb_oh[i]  = i_wb_en && (int'(i_wb_rd) == i);
        end
    end

    // A writeback landing this cycle already releases its register for decode.
    assign eff_pending = pending_q & ~wb_oh;

    assign raw    = (i_id_use_rs1 && |(eff_pending & rs1_oh))
                 || (i_id_use_rs2 && |(eff_pending & rs2_oh));
    assign waw    = i_id_regwrite && |(eff_pending & rd_oh);
    assign ser_ok = !i_id_serialize || (eff_pending == '0);

    assign o_issue = i_id_valid && !i_flush && !i_ex_stall
                  && !raw && !waw && ser_ok;
    assign o_stall = i_id_valid && !i_flush && !o_issue;

    // Clear from writeback first, then set from issue so a same-cycle set wins.
    always_comb begin
        pending_d = pending_q & ~wb_oh;
        if (o_issue && i_id_regwrite) begin
            pending_d = pending_d | rd_oh;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (o_stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    // FSM: state register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (i_id_valid && i_id_serialize && !i_flush && !o_issue) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (o_issue || i_flush || !i_id_valid) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // FSM: outputs
    always_comb begin
        o_drain = (state_q == DRAIN);
    end

    assign o_pending      = pending_q;
    assign o_empty        = (pending_q == '0);
    assign o_stall_cycles = cnt_q;

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// tb_scoreboard_ctrl: vector table plus hand sequences for scoreboard_ctrl.
// Counter runs at CNTW=4 so saturation is reachable quickly.
module tb_scoreboard_ctrl;

    localparam int NREG = 32;
    localparam int CNTW = 4;

    logic            clk = 1'b0;
    logic            rstn;
    logic            id_valid;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic            use1, use2, regwrite, serialize;
    logic            ex_stall, flush, wb_en;
    logic [4:0]      wb_rd;
    logic            issue, stall, empty, drain;
    logic [NREG-1:0] pending;
    logic [CNTW-1:0] cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    scoreboard_ctrl #(.NREG(NREG), .CNTW(CNTW)) dut (
        .i_clk          (clk),
        .i_rstn         (rstn),
        .i_id_valid     (id_valid),
        .i_id_rs1       (id_rs1),
        .i_id_rs2       (id_rs2),
        .i_id_rd        (id_rd),
        .i_id_use_rs1   (use1),
        .i_id_use_rs2   (use2),
        .i_id_regwrite  (regwrite),
        .i_id_serialize (serialize),
        .i_ex_stall     (ex_stall),
        .i_flush        (flush),
        .i_wb_en        (wb_en),
        .i_wb_rd        (wb_rd),
        .o_issue        (issue),
        .o_stall        (stall),
        .o_pending      (pending),
        .o_empty        (empty),
        .o_drain        (drain),
        .o_stall_cycles (cnt)
    );

    typedef struct {
        logic       valid;
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, rw, ser, exst, fl, wben;
        logic [4:0] wbrd;
        logic       e_issue, e_stall;
        logic [31:0] e_pend;
        logic       e_drain;
        logic [3:0] e_cnt;
    } vec_t;

    typedef struct {
        logic [31:0] pend;
        logic        drn;
        logic [3:0]  c;
        int          idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mkv(
        logic v, logic [4:0] r1, logic [4:0] r2, logic [4:0] d,
        logic a1, logic a2, logic w, logic s, logic x, logic f,
        logic we, logic [4:0] wr,
        logic ei, logic es, logic [31:0] ep, logic ed, logic [3:0] ec);
        vec_t t;
        t.valid = v;  t.rs1 = r1; t.rs2 = r2; t.rd = d;
        t.u1 = a1;    t.u2 = a2;  t.rw = w;   t.ser = s;
        t.exst = x;   t.fl = f;   t.wben = we; t.wbrd = wr;
        t.e_issue = ei; t.e_stall = es; t.e_pend = ep;
        t.e_drain = ed; t.e_cnt = ec;
        return t;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        use1 = 0; use2 = 0; regwrite = 0; serialize = 0;
        ex_stall = 0; flush = 0; wb_en = 0; wb_rd = 0;
    endtask

    task automatic drive(vec_t t);
        id_valid = t.valid; id_rs1 = t.rs1; id_rs2 = t.rs2; id_rd = t.rd;
        use1 = t.u1; use2 = t.u2; regwrite = t.rw; serialize = t.ser;
        ex_stall = t.exst; flush = t.fl; wb_en = t.wben; wb_rd = t.wbrd;
    endtask

    initial begin
        exp_t e;
        // valid rs1 rs2 rd u1 u2 rw ser exst fl wben wbrd | issue stall pend drain cnt
        vecs.push_back(mkv(0, 0, 0, 0, 0,0,0,0,0,0, 0,0,  0,0, 32'h0,   0, 0));
        vecs.push_back(mkv(1, 0, 0, 5, 0,0,1,0,0,0, 0,0,  1,0, 32'h20,  0, 0));
        vecs.push_back(mkv(1, 5, 0, 6, 1,0,1,0,0,0, 0,0,  0,1, 32'h20,  0, 1));
        vecs.push_back(mkv(1, 5, 0, 6, 1,0,1,0,0,0, 0,0,  0,1, 32'h20,  0, 2));
        vecs.push_back(mkv(1, 5, 0, 6, 1,0,1,0,0,0, 1,5,  1,0, 32'h40,  0, 2));
        vecs.push_back(mkv(1, 0, 0, 0, 0,0,1,0,0,0, 0,0,  1,0, 32'h40,  0, 2));
        vecs.push_back(mkv(1, 0, 0, 0, 1,1,0,0,0,0, 0,0,  1,0, 32'h40,  0, 2));
        vecs.push_back(mkv(0, 0, 0, 0, 0,0,0,0,0,0, 1,6,  0,0, 32'h0,   0, 2));
        vecs.push_back(mkv(1, 0, 0, 7, 0,0,1,0,0,0, 0,0,  1,0, 32'h80,  0, 2));
        vecs.push_back(mkv(1, 0, 0, 7, 0,0,1,0,0,0, 1,7,  1,0, 32'h80,  0, 2));
        vecs.push_back(mkv(1, 0, 0, 7, 0,0,1,0,0,0, 0,0,  0,1, 32'h80,  0, 3));
        vecs.push_back(mkv(0, 0, 0, 0, 0,0,0,0,0,0, 1,7,  0,0, 32'h0,   0, 3));
        vecs.push_back(mkv(1, 0, 0, 3, 0,0,1,0,0,0, 0,0,  1,0, 32'h8,   0, 3));
        vecs.push_back(mkv(1, 0, 0, 4, 0,0,1,0,0,0, 0,0,  1,0, 32'h18,  0, 3));
        vecs.push_back(mkv(1, 0, 0, 0, 0,0,0,1,0,0, 0,0,  0,1, 32'h18,  1, 4));
        vecs.push_back(mkv(1, 0, 0, 0, 0,0,0,1,0,0, 1,3,  0,1, 32'h10,  1, 5));
        vecs.push_back(mkv(1, 0, 0, 0, 0,0,0,1,0,0, 1,4,  1,0, 32'h0,   0, 5));
        vecs.push_back(mkv(1, 0, 0, 8, 0,0,1,0,1,0, 0,0,  0,1, 32'h0,   0, 6));
        vecs.push_back(mkv(1, 0, 0, 9, 0,0,1,0,0,0, 0,0,  1,0, 32'h200, 0, 6));
        vecs.push_back(mkv(1, 9, 0, 0, 1,0,0,0,0,1, 0,0,  0,0, 32'h200, 0, 6));
        vecs.push_back(mkv(1, 0, 0,10, 0,0,1,0,0,1, 0,0,  0,0, 32'h200, 0, 6));
        vecs.push_back(mkv(1, 0, 0, 0, 0,0,0,1,0,1, 0,0,  0,0, 32'h200, 0, 6));
        vecs.push_back(mkv(1, 0, 0, 0, 0,0,0,1,0,0, 0,0,  0,1, 32'h200, 1, 7));
        vecs.push_back(mkv(1, 0, 0, 0, 0,0,0,1,0,1, 0,0,  0,0, 32'h200, 0, 7));
        vecs.push_back(mkv(1, 0, 0, 0, 0,0,0,1,0,0, 0,0,  0,1, 32'h200, 1, 8));
        vecs.push_back(mkv(0, 0, 0, 0, 0,0,0,1,0,0, 0,0,  0,0, 32'h200, 0, 8));
        vecs.push_back(mkv(0, 0, 0, 0, 0,0,0,0,0,0, 1,12, 0,0, 32'h200, 0, 8));
        vecs.push_back(mkv(0, 0, 0, 0, 0,0,0,0,0,0, 1,0,  0,0, 32'h200, 0, 8));
        vecs.push_back(mkv(1, 9, 9, 0, 1,1,0,0,0,0, 1,9,  1,0, 32'h0,   0, 8));

        idle_inputs();
        rstn = 1'b0;
        #2;
        chk("rst_pending", 64'(pending), 64'h0);
        chk("rst_empty",   64'(empty),   64'h1);
        chk("rst_drain",   64'(drain),   64'h0);
        chk("rst_cnt",     64'(cnt),     64'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            e.pend = vecs[i].e_pend;
            e.drn  = vecs[i].e_drain;
            e.c    = vecs[i].e_cnt;
            e.idx  = i;
            sb.push_back(e);
            @(negedge clk);
            chk($sformatf("v%0d_issue", i), 64'(issue), 64'(vecs[i].e_issue));
            chk($sformatf("v%0d_stall", i), 64'(stall), 64'(vecs[i].e_stall));
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(0), 64'(1));
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d_pend", e.idx),  64'(pending), 64'(e.pend));
                chk($sformatf("v%0d_empty", e.idx), 64'(empty),   64'(e.pend == 0));
                chk($sformatf("v%0d_drain", e.idx), 64'(drain),   64'(e.drn));
                chk($sformatf("v%0d_cnt", e.idx),   64'(cnt),     64'(e.c));
            end
        end

        // Counter saturation: 20 ex_stall cycles from a count of 8.
        idle_inputs();
        id_valid = 1; ex_stall = 1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
        end
        #1;
        chk("sat_cnt", 64'(cnt), 64'hf);
        @(negedge clk);
        chk("sat_stall", 64'(stall), 64'h1);
        @(posedge clk);
        #1;
        chk("sat_hold", 64'(cnt), 64'hf);

        // Build state: pending x11, then a serialize stall into DRAIN.
        idle_inputs();
        id_valid = 1; id_rd = 11; regwrite = 1;
        @(posedge clk);
        #1;
        chk("pre_pend", 64'(pending), 64'h800);
        idle_inputs();
        id_valid = 1; serialize = 1;
        @(posedge clk);
        #1;
        chk("pre_drain", 64'(drain), 64'h1);

        // Asynchronous reset between edges.
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_pend",  64'(pending), 64'h0);
        chk("arst_empty", 64'(empty),   64'h1);
        chk("arst_drain", 64'(drain),   64'h0);
        chk("arst_cnt",   64'(cnt),     64'h0);
        chk("arst_issue", 64'(issue),   64'h1);
        chk("arst_stall", 64'(stall),   64'h0);
        @(negedge clk);
        rstn = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        chk("post_pend",  64'(pending), 64'h0);
        chk("post_drain", 64'(drain),   64'h0);
        chk("sb_empty",   64'(sb.size()), 64'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/scoreboard_ctrl.md
SCOREBOARD_CTRL -- requirements
Module: scoreboard_ctrl

Interface
REQ-001 SHALL have parameter NREG, default 32, number of architectural integer registers (x0..x31).
REQ-002 SHALL have parameter CNTW, default 16, width of the stall-cycle counter.
REQ-003 SHALL have i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have i_rstn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have i_id_valid  input  1  decode stage holds a valid instruction.
REQ-006 SHALL have i_id_rs1 / i_id_rs2 / i_id_rd  input  5 each  source and destination register numbers from the decoded instruction.
REQ-007 SHALL have i_id_use_rs1 / i_id_use_rs2  input  1 each  instruction reads rs1 / rs2.
REQ-008 SHALL have i_id_regwrite  input  1  instruction writes rd.
REQ-009 SHALL have i_id_serialize  input  1  instruction must issue with no writes outstanding (CSR, atomic, exception).
REQ-010 SHALL have i_ex_stall  input  1  downstream cannot accept an instruction this cycle.
REQ-011 SHALL have i_flush  input  1  discard the decode-stage instruction this cycle.
REQ-012 SHALL have i_wb_en / i_wb_rd  input  1 / 5  register-file write completing this cycle.
REQ-013 SHALL have o_issue  output  1  decode instruction is accepted this cycle.
REQ-014 SHALL have o_stall  output  1  decode instruction is valid and held this cycle.
REQ-015 SHALL have o_pending  output  NREG  registered pending-write bit per register.
REQ-016 SHALL have o_empty  output  1  no pending writes (o_pending == 0).
REQ-017 SHALL have o_drain  output  1  FSM is in DRAIN.
REQ-018 SHALL have o_stall_cycles  output  CNTW  saturating count of cycles with o_stall high.

Function
REQ-019 SHALL compute eff_pending = o_pending with bit i_wb_rd cleared when i_wb_en (same-cycle writeback release).
REQ-020 SHALL flag RAW hazard when (use_rs1 & eff_pending[rs1]) | (use_rs2 & eff_pending[rs2]).
REQ-021 SHALL flag WAW hazard when i_id_regwrite & eff_pending[rd].
REQ-022 SHALL treat register 0 as never pending; bit 0 of o_pending SHALL be constant 0.
REQ-023 SHALL drive o_issue = i_id_valid & !i_flush & !i_ex_stall & !RAW & !WAW & (!i_id_serialize | eff_pending == 0), combinationally.
REQ-024 SHALL drive o_stall = i_id_valid & !i_flush & !o_issue.
REQ-025 SHALL, on issue with i_id_regwrite and rd != 0, set o_pending[rd] at the next edge.
REQ-026 SHALL, on i_wb_en with i_wb_rd != 0, clear o_pending[i_wb_rd] at the next edge; set from REQ-025 SHALL win when both target the same register in one cycle.
REQ-027 SHALL NOT clear o_pending on i_flush; in-flight older writes still retire.
REQ-028 SHALL implement FSM states RUN and DRAIN: RUN->DRAIN when i_id_valid & i_id_serialize & !i_flush & !o_issue; DRAIN->RUN when o_issue or i_flush or !i_id_valid.
REQ-029 SHALL increment o_stall_cycles by 1 each cycle o_stall is high, holding at all-ones.
REQ-030 SHALL keep i_wb_en to a non-pending register harmless (no state change).

Reset
REQ-031 SHALL, while i_rstn is low, force o_pending = 0, FSM = RUN, o_stall_cycles = 0, independent of i_clk.
REQ-032 SHALL give o_empty = 1, o_drain = 0 during and immediately after reset; o_issue/o_stall remain combinational from inputs and reset-state values.
REQ-033 SHALL discard all pending bits when reset asserts mid-operation; no writeback afterwards is required to clear them.

Verification
REQ-034 SHALL cover RAW: issue rd=5 regwrite; next cycle rs1=5 -> o_stall=1, o_issue=0 until i_wb_en,i_wb_rd=5, in which cycle o_issue=1.
REQ-035 SHALL cover x0: issue rd=0 regwrite, then rs1=0 -> o_pending=0, no stall.
REQ-036 SHALL cover same-cycle wb/issue: o_pending[7]=1, i_wb_rd=7 with new rd=7 issue -> o_issue=1, o_pending[7]=1 next cycle.
REQ-037 SHALL cover serialize: pending {3,4}, serialize instr valid -> o_drain=1, stall until both retire, then o_issue=1, o_drain=0.
REQ-038 SHALL cover flush and ex_stall: hazard-free instr with i_ex_stall=1 -> o_stall=1; with i_flush=1 -> o_issue=0, o_stall=0, o_pending unchanged.
REQ-039 SHALL cover counter saturation and async reset: CNTW=4, 20 stall cycles -> o_stall_cycles=15; assert i_rstn=0 between edges -> all state cleared immediately.
